mux_sel_sequencer: RTL and testbench

//  Upstream select generator for the N-bit combinational source mux.

---
 rtl/mux_sel_sequencer_pkg.sv | 14 +
 rtl/mux_sel_sequencer_if.sv | 27 ++
 rtl/step_sync_edge.sv | 30 +++
 rtl/mux_sel_sequencer.sv | 111 +++++++++++
 tb/tb_mux_sel_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and defaults for the mux select sequencer.
package mux_sel_sequencer_pkg;

  localparam int SEL_W_DEF   = 2;
  localparam int NUM_SRC_DEF = 3;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_AUTO   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Control/status bundle between a sequencer user (master) and the sequencer (slave).
interface mux_sel_sequencer_if
  import mux_sel_sequencer_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);

  logic               en;
  logic               mode;
  logic               step;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   sel;
  logic               sel_chg;
  logic               wrap;

  modport master (
    output en, mode, step, dwell,
    input  sel, sel_chg, wrap
  );

  modport slave (
    input  en, mode, step, dwell,
    output sel, sel_chg, wrap
  );

endinterface

// File: rtl/step_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous level input.
// rise is high for exactly one cycle, starting the cycle after the second
// synchronizer stage captures the new level.
module step_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain (s1, s2) and one-cycle delayed copy (s3) for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select generator for the source mux: steps sel on button presses (MANUAL)
// or every dwell+1 cycles (AUTO), never producing a code >= NUM_SRC.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   S_IDLE   | disabled; sel held, dwell counter cleared, presses dropped
//   S_MANUAL | one advance per synchronized step rising edge
//   S_AUTO   | advance when dwell counter reaches dwell, presses dropped
//
// The state register follows en/mode every cycle, and actions use the
// current state, so en/mode changes take effect one cycle later.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_sequencer_if.slave bus
);

  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(NUM_SRC - 1);
  localparam logic [SEL_W:0]   LP_NSRC = (SEL_W + 1)'(NUM_SRC);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic               w_rise;
  logic               w_adv;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_sel_chg;
  logic               r_wrap;

  step_sync_edge u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.step),
    .rise  (w_rise)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state from en/mode; advance decision and dwell counter from current state.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_adv       = 1'b0;
    w_cnt_nxt   = '0;
    if (bus.en) begin
      w_state_nxt = bus.mode ? S_AUTO : S_MANUAL;
    end
    case (r_state)
      S_MANUAL: begin
        w_adv = w_rise;
      end
      S_AUTO: begin
        // >= rather than == so lowering dwell below the running count
        // advances immediately instead of waiting for the counter to wrap.
        if (r_cnt >= bus.dwell) begin
          w_adv = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Select register with change and wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_sel_chg <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_adv) begin
      r_sel     <= (r_sel == LP_LAST) ? '0 : r_sel + SEL_W'(1);
      r_sel_chg <= 1'b1;
      r_wrap    <= (r_sel == LP_LAST);
    end else begin
      r_sel_chg <= 1'b0;
      r_wrap    <= 1'b0;
    end
  end

  assign bus.sel     = r_sel;
  assign bus.sel_chg = r_sel_chg;
  assign bus.wrap    = r_wrap;

  // Codes at or above NUM_SRC select an undriven mux leg and must never appear.
  a_sel_legal : assert property (@(posedge clk) disable iff (!rst_n) ({1'b0, r_sel} < LP_NSRC));

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_sel_sequencer_if #(.SEL_W(2), .DWELL_W(8)) if3 ();
  mux_sel_sequencer_if #(.SEL_W(2), .DWELL_W(8)) if4 ();
  mux_sel_sequencer_if #(.SEL_W(2), .DWELL_W(8)) if1 ();

  mux_sel_sequencer #(.SEL_W(2), .NUM_SRC(3), .DWELL_W(8)) dut (
    .clk (clk), .rst_n (rst_n), .bus (if3.slave)
  );
  mux_sel_sequencer #(.SEL_W(2), .NUM_SRC(4), .DWELL_W(8)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (if4.slave)
  );
  mux_sel_sequencer #(.SEL_W(2), .NUM_SRC(1), .DWELL_W(8)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if3.en = 1'b1; if3.mode = 1'b1; if3.dwell = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if3.step = i[0];
      tick();
      n_checks++;
      if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got sel=%0d chg=%b wrap=%b, want 0 0 0",
                 i, if3.sel, if3.sel_chg, if3.wrap);
      end
    end
    if3.en = 1'b0; if3.step = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got sel=%0d chg=%b wrap=%b, want 0 0 0",
               if3.sel, if3.sel_chg, if3.wrap);
    end
  endtask

  task automatic test_manual();
    logic [1:0] exp_sel  [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic       exp_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] prev;
    prev = 2'd0;
    if3.en = 1'b1; if3.mode = 1'b0; if3.step = 1'b0;
    tick();
    for (int p = 0; p < 4; p++) begin
      if3.step = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_checks++;
        if (c < 2) begin
          if ({if3.sel, if3.sel_chg, if3.wrap} !== {prev, 2'b00}) begin
            n_fail++;
            $display("FAIL manual_latency p%0d c%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=0 wrap=0",
                     p, c, if3.sel, if3.sel_chg, if3.wrap, prev);
          end
        end else begin
          if ({if3.sel, if3.sel_chg, if3.wrap} !== {exp_sel[p], 1'b1, exp_wrap[p]}) begin
            n_fail++;
            $display("FAIL manual_advance p%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=1 wrap=%b",
                     p, if3.sel, if3.sel_chg, if3.wrap, exp_sel[p], exp_wrap[p]);
          end
        end
      end
      if3.step = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        n_checks++;
        if ({if3.sel, if3.sel_chg, if3.wrap} !== {exp_sel[p], 2'b00}) begin
          n_fail++;
          $display("FAIL manual_single p%0d c%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=0 wrap=0",
                   p, c, if3.sel, if3.sel_chg, if3.wrap, exp_sel[p]);
        end
      end
      prev = exp_sel[p];
    end
  endtask

  task automatic test_auto();
    logic [1:0] exp_a [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [1:0] exp_b [4] = '{2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] cur;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    if3.en = 1'b1; if3.mode = 1'b1; if3.dwell = 8'd3;
    tick();
    cur = 2'd0;
    for (int a = 0; a < 4; a++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        n_checks++;
        if (c < 3) begin
          if ({if3.sel, if3.sel_chg, if3.wrap} !== {cur, 2'b00}) begin
            n_fail++;
            $display("FAIL auto_dwell3_wait a%0d c%0d: got sel=%0d chg=%b, want sel=%0d chg=0",
                     a, c, if3.sel, if3.sel_chg, cur);
          end
        end else begin
          if ({if3.sel, if3.sel_chg, if3.wrap} !== {exp_a[a], 1'b1, (exp_a[a] == 2'd0)}) begin
            n_fail++;
            $display("FAIL auto_dwell3_adv a%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=1 wrap=%b",
                     a, if3.sel, if3.sel_chg, if3.wrap, exp_a[a], (exp_a[a] == 2'd0));
          end
        end
      end
      cur = exp_a[a];
    end
    if3.dwell = 8'd0;
    for (int a = 0; a < 4; a++) begin
      tick();
      n_checks++;
      if ({if3.sel, if3.sel_chg, if3.wrap} !== {exp_b[a], 1'b1, (exp_b[a] == 2'd0)}) begin
        n_fail++;
        $display("FAIL auto_dwell0 a%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=1 wrap=%b",
                 a, if3.sel, if3.sel_chg, if3.wrap, exp_b[a], (exp_b[a] == 2'd0));
      end
    end
  endtask

  task automatic test_hold_ignore();
    logic [1:0] cur;
    logic       exp_chg;
    // en drops while AUTO with dwell=0: one more advance (state acts one cycle late).
    if3.en = 1'b0;
    tick();
    n_checks++;
    if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0011) begin
      n_fail++;
      $display("FAIL hold_late_advance: got sel=%0d chg=%b wrap=%b, want sel=0 chg=1 wrap=1",
               if3.sel, if3.sel_chg, if3.wrap);
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 8; c++) begin
        if3.step = (c < 3);
        tick();
        n_checks++;
        if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0000) begin
          n_fail++;
          $display("FAIL hold_frozen p%0d c%0d: got sel=%0d chg=%b wrap=%b, want 0 0 0",
                   p, c, if3.sel, if3.sel_chg, if3.wrap);
        end
      end
    end
    // Rise lands in the last IDLE cycle: it must be dropped, not replayed in MANUAL.
    if3.step = 1'b1;
    tick();
    tick();
    if3.en = 1'b1; if3.mode = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if3.step = 1'b0;
      n_checks++;
      if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0000) begin
        n_fail++;
        $display("FAIL no_stale c%0d: got sel=%0d chg=%b wrap=%b, want 0 0 0",
                 c, if3.sel, if3.sel_chg, if3.wrap);
      end
    end
    if3.step = 1'b1;
    tick(); tick(); tick();
    if3.step = 1'b0;
    n_checks++;
    if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0110) begin
      n_fail++;
      $display("FAIL reenable_press: got sel=%0d chg=%b wrap=%b, want sel=1 chg=1 wrap=0",
               if3.sel, if3.sel_chg, if3.wrap);
    end
    // AUTO with presses: only dwell-timed advances.
    if3.mode = 1'b1; if3.dwell = 8'd3;
    tick();
    cur = 2'd1;
    for (int i = 0; i < 12; i++) begin
      if3.step = ((i % 8) < 3);
      tick();
      exp_chg = ((i % 4) == 3);
      if (exp_chg) cur = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
      n_checks++;
      if ({if3.sel, if3.sel_chg, if3.wrap} !== {cur, exp_chg, exp_chg && (cur == 2'd0)}) begin
        n_fail++;
        $display("FAIL auto_ignore_step i%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=%b wrap=%b",
                 i, if3.sel, if3.sel_chg, if3.wrap, cur, exp_chg, exp_chg && (cur == 2'd0));
      end
    end
    if3.step = 1'b0;
  endtask

  task automatic test_mid_op();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    if3.en = 1'b1; if3.mode = 1'b1; if3.dwell = 8'd10; if3.step = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({if3.sel, if3.sel_chg} !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_count c%0d: got sel=%0d chg=%b, want sel=0 chg=0", c, if3.sel, if3.sel_chg);
      end
    end
    if3.mode = 1'b0;
    tick();
    tick();
    if3.mode = 1'b1;
    tick();
    for (int c = 0; c < 11; c++) begin
      tick();
      n_checks++;
      if ({if3.sel, if3.sel_chg} !== ((c == 10) ? 3'b011 : 3'b000)) begin
        n_fail++;
        $display("FAIL reentry_dwell c%0d: got sel=%0d chg=%b, want sel=%0d chg=%b",
                 c, if3.sel, if3.sel_chg, (c == 10), (c == 10));
      end
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      n_checks++;
      if ({if3.sel, if3.sel_chg} !== 3'b010) begin
        n_fail++;
        $display("FAIL pre_lower c%0d: got sel=%0d chg=%b, want sel=1 chg=0", c, if3.sel, if3.sel_chg);
      end
    end
    if3.dwell = 8'd2;
    tick();
    n_checks++;
    if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b1010) begin
      n_fail++;
      $display("FAIL dwell_lowered: got sel=%0d chg=%b wrap=%b, want sel=2 chg=1 wrap=0",
               if3.sel, if3.sel_chg, if3.wrap);
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if3.sel, if3.sel_chg, if3.wrap} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got sel=%0d chg=%b wrap=%b, want 0 0 0",
               if3.sel, if3.sel_chg, if3.wrap);
    end
    rst_n = 1'b1;
    if3.en = 1'b0;
  endtask

  task automatic test_params();
    logic [1:0] exp4 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0; #1; rst_n = 1'b1;
    if4.en = 1'b1; if4.mode = 1'b1; if4.dwell = 8'd0;
    if1.en = 1'b1; if1.mode = 1'b1; if1.dwell = 8'd0;
    tick();
    n_checks++;
    if ({if4.sel_chg, if1.sel_chg} !== 2'b00) begin
      n_fail++;
      $display("FAIL params_enter: got chg4=%b chg1=%b, want 0 0", if4.sel_chg, if1.sel_chg);
    end
    for (int a = 0; a < 5; a++) begin
      tick();
      n_checks++;
      if ({if4.sel, if4.sel_chg, if4.wrap} !== {exp4[a], 1'b1, (a == 3)}) begin
        n_fail++;
        $display("FAIL nsrc4 a%0d: got sel=%0d chg=%b wrap=%b, want sel=%0d chg=1 wrap=%b",
                 a, if4.sel, if4.sel_chg, if4.wrap, exp4[a], (a == 3));
      end
      n_checks++;
      if ({if1.sel, if1.sel_chg, if1.wrap} !== 4'b0011) begin
        n_fail++;
        $display("FAIL nsrc1 a%0d: got sel=%0d chg=%b wrap=%b, want sel=0 chg=1 wrap=1",
                 a, if1.sel, if1.sel_chg, if1.wrap);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if3.en = 1'b0; if3.mode = 1'b0; if3.step = 1'b0; if3.dwell = 8'd0;
    if4.en = 1'b0; if4.mode = 1'b0; if4.step = 1'b0; if4.dwell = 8'd0;
    if1.en = 1'b0; if1.mode = 1'b0; if1.step = 1'b0; if1.dwell = 8'd0;
    test_reset();
    test_manual();
    test_auto();
    test_hold_ignore();
    test_mid_op();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
